// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: streams PC, register bank and (with DUMP_DATA_MEM_EN)
// data memory out over a byte-wide UART, MSB first per word.
module debug_dump_sequencer #(
  parameter int BYTE    = 8,
  parameter int DWORD   = 32,
  parameter int RB_ADDR = 5,
  parameter int ADDR    = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [DWORD-1:0]   i_pc_value,
  input  logic [DWORD-1:0]   i_rb_data,
  input  logic [DWORD-1:0]   i_mem_data,
  input  logic               i_tx_done,
  output logic [RB_ADDR-1:0] o_rb_addr,
  output logic               o_rb_read_enable,
  output logic [ADDR-1:0]    o_mem_addr,
  output logic               o_mem_read_enable,
  output logic               o_mem_du_flag,
  output logic [BYTE-1:0]    o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB = DWORD / BYTE;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_B = CW'(NB - 1);
  localparam logic [RB_ADDR-1:0] RB_LAST = '1;

  typedef enum logic [2:0] {
    IDLE, PC_SEND, RB_READ, RB_SEND,
    MEM_READ, MEM_SEND, FINISH
  } state_t;

  state_t           state;
  logic [DWORD-1:0] word;
  logic [CW-1:0]    nbyte;
  logic             pend;
  logic             rd_wait;
  logic             sending;
  logic             byte_ack;
  logic             word_end;

  assign sending = (state == PC_SEND) ||
                   (state == RB_SEND) ||
                   (state == MEM_SEND);

  // a done coincident with our own start belongs to an earlier byte
  assign byte_ack = pend && i_tx_done && !o_tx_start;
  assign word_end = byte_ack && (nbyte == LAST_B);

`ifdef DUMP_DATA_MEM_EN
  localparam logic [ADDR-1:0] MEM_LAST = '1;
`else
  logic unused_mem;
  assign unused_mem        = ^i_mem_data;
  assign o_mem_addr        = '0;
  assign o_mem_read_enable = 1'b0;
  assign o_mem_du_flag     = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= IDLE;
      word             <= '0;
      nbyte            <= '0;
      pend             <= 1'b0;
      rd_wait          <= 1'b0;
      o_rb_addr        <= '0;
      o_rb_read_enable <= 1'b0;
      o_tx_data        <= '0;
      o_tx_start       <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
`ifdef DUMP_DATA_MEM_EN
      o_mem_addr        <= '0;
      o_mem_read_enable <= 1'b0;
      o_mem_du_flag     <= 1'b0;
`endif
    end else begin
      o_tx_start       <= 1'b0;
      o_done           <= 1'b0;
      o_rb_read_enable <= 1'b0;
`ifdef DUMP_DATA_MEM_EN
      o_mem_read_enable <= 1'b0;
`endif
      if (sending) begin
        if (!pend) begin
          o_tx_start <= 1'b1;
          o_tx_data  <= word[DWORD-1 -: BYTE];
          word       <= word << BYTE;
          pend       <= 1'b1;
        end else if (byte_ack) begin
          pend  <= 1'b0;
          nbyte <= word_end ? '0 : nbyte + CW'(1);
        end
      end
      unique case (state)
        IDLE: begin
          if (i_start) begin
            word      <= i_pc_value;
            nbyte     <= '0;
            pend      <= 1'b0;
            o_rb_addr <= '0;
            o_busy    <= 1'b1;
            state     <= PC_SEND;
`ifdef DUMP_DATA_MEM_EN
            o_mem_addr <= '0;
`endif
          end
        end
        PC_SEND: begin
          if (word_end) begin
            o_rb_read_enable <= 1'b1;
            rd_wait          <= 1'b0;
            state            <= RB_READ;
          end
        end
        RB_READ: begin
          if (!rd_wait) begin
            rd_wait <= 1'b1;
          end else begin
            word    <= i_rb_data;
            rd_wait <= 1'b0;
            state   <= RB_SEND;
          end
        end
        RB_SEND: begin
          if (word_end) begin
            if (o_rb_addr == RB_LAST) begin
`ifdef DUMP_DATA_MEM_EN
              o_mem_read_enable <= 1'b1;
              o_mem_du_flag     <= 1'b1;
              state             <= MEM_READ;
`else
              o_done <= 1'b1;
              state  <= FINISH;
`endif
            end else begin
              o_rb_addr        <= o_rb_addr + RB_ADDR'(1);
              o_rb_read_enable <= 1'b1;
              state            <= RB_READ;
            end
          end
        end
`ifdef DUMP_DATA_MEM_EN
        MEM_READ: begin
          if (!rd_wait) begin
            rd_wait <= 1'b1;
          end else begin
            word    <= i_mem_data;
            rd_wait <= 1'b0;
            state   <= MEM_SEND;
          end
        end
        MEM_SEND: begin
          if (word_end) begin
            if (o_mem_addr == MEM_LAST) begin
              o_done <= 1'b1;
              state  <= FINISH;
            end else begin
              o_mem_addr        <= o_mem_addr + ADDR'(1);
              o_mem_read_enable <= 1'b1;
              state             <= MEM_READ;
            end
          end
        end
`endif
        FINISH: begin
          o_busy <= 1'b0;
          state  <= IDLE;
`ifdef DUMP_DATA_MEM_EN
          o_mem_du_flag <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: UART responder, bank/memory models and
// a byte-queue reference of the expected dump stream.
module tb_debug_dump_sequencer;

`ifdef DUMP_DATA_MEM_EN
  localparam int TOTAL = 260;
  localparam int MEMRD = 32;
`else
  localparam int TOTAL = 132;
  localparam int MEMRD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] rb_data = '0;
  logic [31:0] mem_data = '0;
  logic        tx_done = 1'b0;
  logic        spur_done = 1'b0;
  logic [4:0]  rb_addr;
  logic        rb_re;
  logic [4:0]  mem_addr;
  logic        mem_re;
  logic        du_flag;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  debug_dump_sequencer dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_start(start),
    .i_pc_value(pc),
    .i_rb_data(rb_data),
    .i_mem_data(mem_data),
    .i_tx_done(tx_done | spur_done),
    .o_rb_addr(rb_addr),
    .o_rb_read_enable(rb_re),
    .o_mem_addr(mem_addr),
    .o_mem_read_enable(mem_re),
    .o_mem_du_flag(du_flag),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_busy(busy),
    .o_done(done)
  );

  logic [31:0] regs [32];
  logic [31:0] mem  [32];
  logic [7:0]  exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int bytes_seen = 0;
  int done_cnt = 0;
  int rb_re_cnt = 0;
  int mem_re_cnt = 0;
  int cnt = 0;
  bit rnd_delay = 0;
  bit coinc = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one-cycle read latency memories
  always @(posedge clk) begin
    if (rb_re) rb_data <= regs[rb_addr];
    if (mem_re) mem_data <= mem[mem_addr];
  end

  // UART responder and stream monitor
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rb_re) rb_re_cnt++;
    if (mem_re) begin
      mem_re_cnt++;
      chk("du_flag_on_mem_read", du_flag, 1);
    end
    if (tx_start) begin
      bytes_seen++;
      chk($sformatf("byte%0d_expected", bytes_seen), exp_q.size() > 0, 1);
      if (exp_q.size() > 0)
        chk($sformatf("byte%0d", bytes_seen), tx_data, exp_q.pop_front());
      cnt = rnd_delay ? int'($urandom_range(1, 4)) : 3;
      if (coinc) tx_done = 1'b1;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0) tx_done = 1'b1;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last_byte", bytes_seen, TOTAL);
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic load_exp(input logic [31:0] p);
    exp_q.delete();
    push_word(p);
    for (int k = 0; k < 32; k++) push_word(regs[k]);
`ifdef DUMP_DATA_MEM_EN
    for (int k = 0; k < 32; k++) push_word(mem[k]);
`endif
    bytes_seen = 0;
    rb_re_cnt  = 0;
    mem_re_cnt = 0;
  endtask

  task automatic run_dump(input logic [31:0] p, input bit spam);
    int d0;
    load_exp(p);
    d0 = done_cnt;
    pc = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 8000 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      start = (spam && busy && !done && (i % 23 == 0));
    end
    start = 1'b0;
    chk("done_seen", done_cnt, d0 + 1);
    repeat (20) @(posedge clk);
    #1;
    chk("single_done", done_cnt, d0 + 1);
    chk("busy_clear", busy, 0);
    chk("bytes_total", bytes_seen, TOTAL);
    chk("queue_empty", exp_q.size(), 0);
    chk("rb_reads", rb_re_cnt, 32);
    chk("mem_reads", mem_re_cnt, MEMRD);
    chk("du_flag_idle", du_flag, 0);
  endtask

  initial begin
    int d0;
    int bad;
    rst = 1'b1;
    start = 1'b0;
    pc = '0;
    for (int k = 0; k < 32; k++) begin
      regs[k] = 32'hA0B0C000 + k;
      mem[k]  = $urandom;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_done", done, 0);
    chk("rst_rb_re", rb_re, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_du_flag", du_flag, 0);
    chk("rst_rb_addr", rb_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    spur_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spur_done = 1'b0;
    chk("idle_spur_busy", busy, 0);
    chk("idle_spur_tx", tx_start, 0);

    run_dump(32'h00400010, 1'b0);

    for (int k = 0; k < 32; k++) begin
      regs[k] = $urandom;
      mem[k]  = $urandom;
    end
    rnd_delay = 1'b1;
    coinc = 1'b1;
    run_dump($urandom, 1'b1);
    coinc = 1'b0;

    load_exp(32'h12345678);
    d0 = done_cnt;
    pc = 32'h12345678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && bytes_seen < 50; i++) begin
      @(posedge clk); #1;
    end
    chk("reached_50_bytes", bytes_seen >= 50, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_rb_addr", rb_addr, 0);
    chk("midrst_du_flag", du_flag, 0);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tx_start || busy) bad++;
    end
    chk("quiet_after_reset", bad, 0);
    chk("no_done_after_reset", done_cnt, d0);

    rnd_delay = 1'b0;
    for (int k = 0; k < 32; k++) regs[k] = 32'hA0B0C000 + k;
    run_dump($urandom, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_dump_sequencer.md
DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 The block SHALL have parameter BYTE, default 8, UART byte width.
REQ-002 The block SHALL have parameter DWORD, default 32, datapath word width.
REQ-003 The block SHALL have parameter RB_ADDR, default 5, register-bank address width (2^RB_ADDR registers).
REQ-004 The block SHALL have parameter ADDR, default 5, data-memory address width (2^ADDR words).
REQ-005 The block SHALL use one clock, i_clock; reset i_reset is synchronous and active-high.
REQ-006 The block SHALL have these ports, one per line:
 i_clock  input  1  system clock
 i_reset  input  1  synchronous active-high reset
 i_start  input  1  one-cycle dump request
 i_pc_value  input  DWORD  last PC from pipeline
 i_rb_data  input  DWORD  register-bank read data
 i_mem_data  input  DWORD  data-memory read data
 i_tx_done  input  1  UART transmitter finished current byte
 o_rb_addr  output  RB_ADDR  register-bank read address
 o_rb_read_enable  output  1  register-bank read strobe
 o_mem_addr  output  ADDR  data-memory read address
 o_mem_read_enable  output  1  data-memory read strobe
 o_mem_du_flag  output  1  data-memory port owned by debug path
 o_tx_data  output  BYTE  byte to transmit
 o_tx_start  output  1  one-cycle transmit request
 o_busy  output  1  dump in progress
 o_done  output  1  one-cycle pulse on dump completion

Function
REQ-007 States SHALL be IDLE, PC_SEND, RB_READ, RB_SEND, MEM_READ, MEM_SEND, FINISH.
REQ-008 IDLE -> PC_SEND on i_start=1; i_start SHALL be ignored in every other state.
REQ-009 PC_SEND SHALL capture i_pc_value in the entry cycle and transmit its 4 bytes MSB first.
REQ-010 Each byte: o_tx_data valid and o_tx_start high for exactly one cycle; next byte's o_tx_start no earlier than one cycle after i_tx_done=1.
REQ-011 i_tx_done SHALL be ignored unless a byte is outstanding; tx_done in the same cycle as o_tx_start SHALL not count.
REQ-012 RB_READ SHALL drive o_rb_addr and o_rb_read_enable=1 for one cycle; i_rb_data SHALL be latched the following cycle (1-cycle read latency), then RB_SEND transmits 4 bytes MSB first.
REQ-013 After RB_SEND, the address SHALL increment; at address 2^RB_ADDR-1 the sequencer SHALL exit to MEM_READ (or FINISH, see REQ-019) without wrapping to 0.
REQ-014 MEM_READ/MEM_SEND SHALL mirror REQ-012/013 using o_mem_addr, o_mem_read_enable and i_mem_data; o_mem_du_flag SHALL be 1 from MEM_READ entry to FINISH.
REQ-015 FINISH SHALL pulse o_done for one cycle then return to IDLE.
REQ-016 o_busy SHALL be 1 in every state except IDLE.
REQ-017 Total bytes per dump: 4 + 4*2^RB_ADDR + 4*2^ADDR (260 at defaults).

Reset
REQ-018 On i_reset=1 at a clock edge, the state SHALL become IDLE, addresses 0, and all outputs 0, including mid-dump with a byte outstanding; no further o_tx_start until a new i_start.

Configuration
REQ-019 Macro DUMP_DATA_MEM_EN: defined -> memory dump per REQ-014; undefined -> RB_SEND of last register goes to FINISH, o_mem_read_enable/o_mem_du_flag tied 0, o_mem_addr tied 0, 132 bytes per dump.

Verification
REQ-020 Reset, pulse i_start, PC=0x00400010, tx_done 3 cycles after each start -> bytes 00 40 00 10 first, then registers, o_done after byte 260.
REQ-021 Register k holds 0xA0B0C000+k -> register 31 bytes A0 B0 C0 1F; o_rb_addr never exceeds 31.
REQ-022 i_start pulsed repeatedly during a dump -> dump continues unchanged, exactly one o_done.
REQ-023 i_reset asserted after 50th byte -> next cycle o_busy=0, o_tx_start=0 for 100 cycles; subsequent i_start restarts with PC bytes.
REQ-024 Spurious i_tx_done in IDLE and coincident with o_tx_start -> no byte skipped, ordering intact.
REQ-025 Build without DUMP_DATA_MEM_EN -> 132 bytes, o_mem_read_enable never 1, o_done after byte 132.
